// File: rtl/anunciador_pkg.sv
// Shared constants for the temperature alarm annunciator:
// state codes, sensor bit positions and default flag count.
package anunciador_pkg;

    localparam logic [1:0] EST_NORMAL      = 2'd0;
    localparam logic [1:0] EST_ALARME      = 2'd1;
    localparam logic [1:0] EST_RECONHECIDO = 2'd2;
    localparam logic [1:0] EST_ESCALADO    = 2'd3;

    typedef enum logic [1:0] {
        ST_NORMAL      = EST_NORMAL,
        ST_ALARME      = EST_ALARME,
        ST_RECONHECIDO = EST_RECONHECIDO,
        ST_ESCALADO    = EST_ESCALADO
    } estado_t;

    localparam int IDX_SC    = 0;
    localparam int IDX_S1    = 1;
    localparam int IDX_S2    = 2;
    localparam int IDX_S3    = 3;
    localparam int IDX_TUBSR = 4;
    localparam int IDX_TUBSS = 5;
    localparam int IDX_REA   = 6;

    localparam int N_SENS_DEF = IDX_REA + 1;

endpackage

// File: rtl/gerador_pulso_sirene.sv
// Siren square-wave generator: half-period of PULSE_DIV cycles,
// restart forces the output high and restarts the count.
module gerador_pulso_sirene #(
    parameter int PULSE_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_restart,
    output logic o_pulso
);

    localparam int CW = $clog2(PULSE_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(PULSE_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_pulso;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_pulso <= 1'b0;
        end else if (i_restart) begin
            r_cnt   <= '0;
            r_pulso <= 1'b1;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_pulso <= ~r_pulso;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulso = r_pulso;

endmodule

// File: rtl/anunciador_alarme_temperatura.sv
// Temperature alarm annunciator: lamp/first-out latching, operator
// acknowledge, escalation to SCRAM and re-arm sequencing.
module anunciador_alarme_temperatura
    import anunciador_pkg::*;
#(
    parameter int N_SENS      = N_SENS_DEF,
    parameter int PULSE_DIV   = 4,
    parameter int ESC_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_SENS-1:0] i_flagTemp,
    input  logic              i_alarmeSonoroTemperatura,
    input  logic              i_reconhecer,
    input  logic              i_rearme,
    output logic              o_sirene,
    output logic [N_SENS-1:0] o_luzes,
    output logic [N_SENS-1:0] o_primeiroAlarme,
    output logic              o_scramReq,
    output logic              o_inconsistencia,
    output logic [1:0]        o_estado
);

    localparam int EW = $clog2(ESC_TIMEOUT) + 1;
    localparam logic [EW-1:0] ESC_LAST = EW'(ESC_TIMEOUT - 1);

    estado_t           r_estado;
    logic [N_SENS-1:0] r_luzes;
    logic [N_SENS-1:0] r_primeiro;
    logic [EW-1:0]     r_esc_cnt;
    logic              r_ack_q;
    logic              r_alarme_q;
    logic              r_incons;

    estado_t           w_estado_nx;
    logic [N_SENS-1:0] w_luzes_nx;
    logic [N_SENS-1:0] w_primeiro_nx;
    logic [EW-1:0]     w_esc_nx;
    logic              w_trip;
    logic              w_ack;
    logic              w_novo;
    logic              w_restart;
    logic              w_en;
    logic              w_pulso;

    assign w_trip = (|i_flagTemp) | i_alarmeSonoroTemperatura;
    assign w_ack  = i_reconhecer & ~r_ack_q;
    // Re-alarm: a flag not currently lit, or a fresh aggregate alarm
    assign w_novo = (|(i_flagTemp & ~r_luzes))
                  | (i_alarmeSonoroTemperatura & ~r_alarme_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_estado   <= ST_NORMAL;
            r_luzes    <= '0;
            r_primeiro <= '0;
            r_esc_cnt  <= '0;
            r_ack_q    <= 1'b0;
            r_alarme_q <= 1'b0;
            r_incons   <= 1'b0;
        end else begin
            r_estado   <= w_estado_nx;
            r_luzes    <= w_luzes_nx;
            r_primeiro <= w_primeiro_nx;
            r_esc_cnt  <= w_esc_nx;
            r_ack_q    <= i_reconhecer;
            r_alarme_q <= i_alarmeSonoroTemperatura;
            r_incons   <= r_incons
                        | (i_alarmeSonoroTemperatura != (|i_flagTemp));
        end
    end

    always_comb begin
        w_estado_nx   = r_estado;
        w_luzes_nx    = r_luzes;
        w_primeiro_nx = r_primeiro;
        w_esc_nx      = r_esc_cnt;
        w_restart     = 1'b0;
        w_en          = 1'b0;
        unique case (r_estado)
            ST_NORMAL: begin
                w_luzes_nx    = '0;
                w_primeiro_nx = '0;
                w_esc_nx      = '0;
                if (w_trip) begin
                    w_estado_nx   = ST_ALARME;
                    w_luzes_nx    = i_flagTemp;
                    w_primeiro_nx = i_flagTemp;
                    w_restart     = 1'b1;
                end
            end
            ST_ALARME: begin
                w_en       = 1'b1;
                w_luzes_nx = r_luzes | i_flagTemp;
                if (r_esc_cnt != '1) begin
                    w_esc_nx = r_esc_cnt + 1'b1;
                end
                if (w_ack) begin
                    w_estado_nx = ST_RECONHECIDO;
                    w_luzes_nx  = r_luzes & i_flagTemp;
                end else if (r_esc_cnt == ESC_LAST) begin
                    w_estado_nx = ST_ESCALADO;
                end
            end
            ST_RECONHECIDO: begin
                w_luzes_nx = i_flagTemp;
                if (w_novo) begin
                    w_estado_nx = ST_ALARME;
                    w_luzes_nx  = r_luzes | i_flagTemp;
                    w_esc_nx    = '0;
                    w_restart   = 1'b1;
                end else if (!w_trip) begin
                    w_estado_nx   = ST_NORMAL;
                    w_luzes_nx    = '0;
                    w_primeiro_nx = '0;
                end
            end
            ST_ESCALADO: begin
                w_luzes_nx = r_luzes | i_flagTemp;
                if (i_rearme && !w_trip) begin
                    w_estado_nx   = ST_NORMAL;
                    w_luzes_nx    = '0;
                    w_primeiro_nx = '0;
                    w_esc_nx      = '0;
                end
            end
        endcase
    end

    gerador_pulso_sirene #(
        .PULSE_DIV (PULSE_DIV)
    ) u_sirene (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (w_en),
        .i_restart (w_restart),
        .o_pulso   (w_pulso)
    );

    assign o_sirene = (r_estado == ST_ALARME) ? w_pulso
                                              : (r_estado == ST_ESCALADO);
    assign o_luzes          = r_luzes;
    assign o_primeiroAlarme = r_primeiro;
    assign o_scramReq       = (r_estado == ST_ESCALADO);
    assign o_inconsistencia = r_incons;
    assign o_estado         = r_estado;

endmodule

// File: tb/tb_anunciador_alarme_temperatura.sv
// Bench for the temperature alarm annunciator: behavioural model feeds
// a scoreboard queue, a monitor compares every cycle after the edge.
module tb_anunciador_alarme_temperatura;

    localparam int NS = 7;
    localparam int PD = 4;
    localparam int ET = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] flagTemp;
    logic          alarme;
    logic          reconhecer;
    logic          rearme;
    logic          sirene;
    logic [NS-1:0] luzes;
    logic [NS-1:0] primeiro;
    logic          scram;
    logic          incons;
    logic [1:0]    estado;

    always #5 clk = ~clk;

    anunciador_alarme_temperatura #(
        .N_SENS      (NS),
        .PULSE_DIV   (PD),
        .ESC_TIMEOUT (ET)
    ) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_flagTemp                (flagTemp),
        .i_alarmeSonoroTemperatura (alarme),
        .i_reconhecer              (reconhecer),
        .i_rearme                  (rearme),
        .o_sirene                  (sirene),
        .o_luzes                   (luzes),
        .o_primeiroAlarme          (primeiro),
        .o_scramReq                (scram),
        .o_inconsistencia          (incons),
        .o_estado                  (estado)
    );

    typedef struct packed {
        logic          sir;
        logic [NS-1:0] luz;
        logic [NS-1:0] prim;
        logic          scr;
        logic          inc;
        logic [1:0]    est;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: alarm phase + latched sets, siren from elapsed time
    int            m_phase;
    int            m_age;
    logic [NS-1:0] m_lit;
    logic [NS-1:0] m_first;
    logic          m_inc;
    logic          m_ack_prev;
    logic          m_al_prev;

    task automatic model(input logic [NS-1:0] f, input logic al,
                         input logic ack, input logic rea, input logic r);
        logic trip;
        logic ack_new;
        logic al_new;
        obs_t e;
        trip    = (f != 0) || al;
        ack_new = ack && !m_ack_prev;
        al_new  = al && !m_al_prev;
        if (r) begin
            m_phase = 0; m_age = 0; m_lit = 0; m_first = 0;
            m_inc = 0; m_ack_prev = 0; m_al_prev = 0;
        end else begin
            if (al != (f != 0)) m_inc = 1;
            case (m_phase)
                0: if (trip) begin
                    m_phase = 1; m_age = 0; m_lit = f; m_first = f;
                end
                1: if (ack_new) begin
                    m_phase = 2; m_lit = m_lit & f;
                end else if (m_age == ET - 1) begin
                    m_phase = 3; m_lit = m_lit | f;
                end else begin
                    m_age = m_age + 1; m_lit = m_lit | f;
                end
                2: if (((f & ~m_lit) != 0) || al_new) begin
                    m_phase = 1; m_age = 0; m_lit = m_lit | f;
                end else if (!trip) begin
                    m_phase = 0; m_lit = 0; m_first = 0;
                end else begin
                    m_lit = f;
                end
                default: begin
                    m_lit = m_lit | f;
                    if (rea && !trip) begin
                        m_phase = 0; m_lit = 0; m_first = 0;
                    end
                end
            endcase
            m_ack_prev = ack;
            m_al_prev  = al;
        end
        e.sir  = (m_phase == 1) ? (((m_age / PD) % 2) == 0)
                                : (m_phase == 3);
        e.luz  = m_lit;
        e.prim = m_first;
        e.scr  = (m_phase == 3);
        e.inc  = m_inc;
        e.est  = 2'(m_phase);
        q.push_back(e);
    endtask

    task automatic step(input logic [NS-1:0] f, input logic al,
                        input logic ack, input logic rea, input logic r);
        flagTemp   = f;
        alarme     = al;
        reconhecer = ack;
        rearme     = rea;
        rst        = r;
        model(f, al, ack, rea, r);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {sirene, luzes, primeiro, scram, incons, estado};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle %0d: got sir=%b luz=%h prim=%h scr=%b inc=%b est=%0d expected sir=%b luz=%h prim=%h scr=%b inc=%b est=%0d",
                             cyc, a.sir, a.luz, a.prim, a.scr, a.inc, a.est,
                             e.sir, e.luz, e.prim, e.scr, e.inc, e.est);
                end
            end
        end
    end

    initial begin : driver
        logic [NS-1:0] f;
        logic al, ack, rea, r;
        flagTemp = 0; alarme = 0; reconhecer = 0; rearme = 0; rst = 1;

        // Reset and idle
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        chk("idle_estado", estado, 0);

        // Rea trip, siren pattern, ack at cycle 5
        for (int i = 1; i <= 8; i++) begin
            step(7'h40, 1, i == 5, 0, 0);
            if (i == 1) chk("t2_estado", estado, 1);
            if (i == 1) chk("t2_first", primeiro, 'h40);
            if (i == 4) chk("t2_sir4", sirene, 1);
            if (i == 5) chk("t2_ack", estado, 2);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Escalation timing and re-arm rules
        for (int i = 1; i <= ET + 1; i++) begin
            step(7'h01, 1, 0, 0, 0);
            if (i == ET) chk("t3_noscram", scram, 0);
        end
        chk("t3_scram", scram, 1);
        step(7'h01, 1, 0, 1, 0);
        chk("t3_rearm_blocked", estado, 3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t3_rearm", estado, 0);

        // Re-alarm from acknowledged state
        step(7'h01, 1, 0, 0, 0);
        step(7'h01, 1, 1, 0, 0);
        step(7'h01, 1, 0, 0, 0);
        step(7'h05, 1, 0, 0, 0);
        chk("t4_realarm", estado, 1);
        chk("t4_luz", luzes, 'h05);
        chk("t4_first", primeiro, 'h01);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("t4_latched", luzes, 'h05);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Ack exactly on the timeout cycle
        for (int i = 1; i <= ET + 1; i++) step(7'h10, 1, i == ET + 1, 0, 0);
        chk("t5_ack_wins", estado, 2);
        step(0, 0, 0, 0, 0);

        // Inconsistency, reset out of ESCALADO with ack held
        for (int i = 0; i < ET + 2; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1);
        chk("t6_reset_scram", scram, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("t6_no_ack", estado, 1);

        // Randomized traffic
        f = 0; ack = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0) f = 0;
                else f = NS'($urandom) & NS'($urandom) & NS'($urandom);
            end
            al = (f != 0);
            if ($urandom_range(0, 49) == 0) al = ~al;
            if ($urandom_range(0, 19) == 0) ack = ~ack;
            rea = ($urandom_range(0, 7) == 0);
            r   = ($urandom_range(0, 299) == 0);
            step(f, al, ack, rea, r);
        end

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
